// File: rtl/clock_pkg.sv
// Shared encodings and default limits for the time-keeping controller.
package clock_pkg;

  typedef enum logic [1:0] {
    MODE_RUN      = 2'd0,
    MODE_SET_SEC  = 2'd1,
    MODE_SET_MIN  = 2'd2,
    MODE_SET_HOUR = 2'd3
  } mode_e;

  localparam int SEC_MAX_DEF  = 59;
  localparam int HOUR_MAX_DEF = 23;
  localparam int SEC_W        = 6;
  localparam int MIN_W        = 6;
  localparam int HOUR_W       = 5;

endpackage

// File: rtl/clock_ctrl_wrap_cnt.sv
// Enabled counter wrapping to 0 after MAX; carry is combinational (en & at-max).
// Uses >= so a stray out-of-range value still wraps on its next increment.
module wrap_cnt
  import clock_pkg::*;
#(
  parameter int WIDTH = SEC_W,
  parameter int MAX   = SEC_MAX_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] value,
  output logic             carry
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  logic [WIDTH-1:0] value_q, value_d;

  assign carry = en & (value_q >= MAX_V);

  always_comb begin
    value_d = value_q;
    if (en) value_d = carry ? '0 : value_q + WIDTH'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) value_q <= '0;
    else     value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: rtl/clock_ctrl.sv
// Seconds/minutes/hours chain driven by a 1 Hz tick, with a 4-state set-mode FSM.
// Optional display blink for the field being set: define CLOCK_CTRL_BLINK_EN.
module clock_ctrl
  import clock_pkg::*;
#(
  parameter int HOUR_MAX = HOUR_MAX_DEF,
  parameter int SEC_MAX  = SEC_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              btn_mode,
  input  logic              btn_inc,
  output logic [SEC_W-1:0]  sec,
  output logic [MIN_W-1:0]  min,
  output logic [HOUR_W-1:0] hour,
  output logic [1:0]        mode,
  output logic              day_wrap,
  output logic              blink
);

  mode_e state_q, state_d;
  logic  run;
  logic  inc_only;
  logic  sec_en, min_en, hour_en;
  logic  sec_carry, min_carry, hour_carry;
  logic  day_wrap_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= MODE_RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (btn_mode) begin
      case (state_q)
        MODE_RUN:      state_d = MODE_SET_SEC;
        MODE_SET_SEC:  state_d = MODE_SET_MIN;
        MODE_SET_MIN:  state_d = MODE_SET_HOUR;
        MODE_SET_HOUR: state_d = MODE_RUN;
        default:       state_d = MODE_RUN;
      endcase
    end
  end

  assign mode = state_q;
  assign run  = (state_q == MODE_RUN);

  // A mode press in the same cycle swallows the increment.
  assign inc_only = btn_inc & ~btn_mode;
  assign sec_en   = (run & tick)      | ((state_q == MODE_SET_SEC)  & inc_only);
  assign min_en   = (run & sec_carry) | ((state_q == MODE_SET_MIN)  & inc_only);
  assign hour_en  = (run & min_carry) | ((state_q == MODE_SET_HOUR) & inc_only);

  wrap_cnt #(.WIDTH(SEC_W), .MAX(SEC_MAX)) u_sec (
    .clk(clk), .rst(rst), .en(sec_en), .value(sec), .carry(sec_carry)
  );

  wrap_cnt #(.WIDTH(MIN_W), .MAX(SEC_MAX)) u_min (
    .clk(clk), .rst(rst), .en(min_en), .value(min), .carry(min_carry)
  );

  wrap_cnt #(.WIDTH(HOUR_W), .MAX(HOUR_MAX)) u_hour (
    .clk(clk), .rst(rst), .en(hour_en), .value(hour), .carry(hour_carry)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) day_wrap_q <= 1'b0;
    else     day_wrap_q <= run & hour_carry;
  end

  assign day_wrap = day_wrap_q;

`ifdef CLOCK_CTRL_BLINK_EN
  logic blink_q, blink_d;

  always_comb begin
    blink_d = blink_q;
    if (btn_mode)     blink_d = (state_d != MODE_RUN);
    else if (run)     blink_d = 1'b0;
    else if (btn_inc) blink_d = 1'b1;
    else if (tick)    blink_d = ~blink_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) blink_q <= 1'b0;
    else     blink_q <= blink_d;
  end

  assign blink = blink_q;
`else
  assign blink = 1'b0;
`endif

endmodule

// File: tb/tb_clock_ctrl.sv
// Directed bench for clock_ctrl: stimulus pushes expected snapshots tagged with
// the edge they apply to; a monitor pops and compares one cycle-aligned snapshot.
module tb_clock_ctrl;

`ifdef CLOCK_CTRL_BLINK_EN
  localparam logic BL = 1'b1;
`else
  localparam logic BL = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic [5:0] sec;
  logic [5:0] min;
  logic [4:0] hour;
  logic [1:0] mode;
  logic       day_wrap;
  logic       blink;

  clock_ctrl #(.HOUR_MAX(23), .SEC_MAX(59)) dut (
    .clk(clk), .rst(rst), .tick(tick), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .sec(sec), .min(min), .hour(hour), .mode(mode), .day_wrap(day_wrap),
    .blink(blink)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    string      name;
    logic [5:0] s;
    logic [5:0] m;
    logic [4:0] h;
    logic [1:0] md;
    logic       dw;
    logic       bl;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  // Monitor: after every rising edge compare any snapshot due on that edge.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        exp_t e;
        e = exp_q.pop_front();
        checks++;
        if (e.cyc != cyc ||
            {sec, min, hour, mode, day_wrap, blink} !==
            {e.s, e.m, e.h, e.md, e.dw, e.bl}) begin
          failures++;
          $display("FAIL %s: got %0d:%0d:%0d mode=%0d wrap=%0b blink=%0b, want %0d:%0d:%0d mode=%0d wrap=%0b blink=%0b",
                   e.name, hour, min, sec, mode, day_wrap, blink,
                   e.h, e.m, e.s, e.md, e.dw, e.bl);
        end
      end
    end
  end

  task automatic step(input logic t, input logic m, input logic i);
    @(negedge clk);
    tick = t;
    btn_mode = m;
    btn_inc = i;
  endtask

  task automatic expect_at(input string name, input int s, input int mi, input int h,
                           input int md, input logic dw, input logic bl);
    exp_t e;
    e.cyc = cyc + 1;
    e.name = name;
    e.s = 6'(s);
    e.m = 6'(mi);
    e.h = 5'(h);
    e.md = 2'(md);
    e.dw = dw;
    e.bl = bl;
    exp_q.push_back(e);
  endtask

  task automatic repeat_step(input int n, input logic t, input logic m, input logic i);
    for (int k = 0; k < n; k++) step(t, m, i);
  endtask

  initial begin
    @(negedge clk);
    expect_at("reset_state", 0, 0, 0, 0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    repeat_step(37, 1'b1, 1'b0, 1'b0);
    expect_at("count_37", 37, 0, 0, 0, 1'b0, 1'b0);

    @(negedge clk);
    tick = 1'b0;
    rst = 1'b1;
    expect_at("reset_mid_count", 0, 0, 0, 0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    step(1'b0, 1'b1, 1'b0);
    expect_at("enter_set_sec", 0, 0, 0, 1, 1'b0, BL);
    repeat_step(59, 1'b0, 1'b0, 1'b1);
    expect_at("set_sec_59", 59, 0, 0, 1, 1'b0, BL);
    step(1'b0, 1'b1, 1'b0);
    repeat_step(59, 1'b0, 1'b0, 1'b1);
    expect_at("set_min_59", 59, 59, 0, 2, 1'b0, BL);
    step(1'b0, 1'b0, 1'b1);
    expect_at("set_min_wrap_no_carry", 59, 0, 0, 2, 1'b0, BL);
    repeat_step(5, 1'b1, 1'b0, 1'b0);
    expect_at("set_min_ticks_frozen", 59, 0, 0, 2, 1'b0, 1'b0);
    repeat_step(59, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    expect_at("back_to_run", 59, 59, 0, 0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    expect_at("hour_carry", 0, 0, 1, 0, 1'b0, 1'b0);

    step(1'b0, 1'b1, 1'b0);
    repeat_step(59, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    repeat_step(59, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    repeat_step(22, 1'b0, 1'b0, 1'b1);
    expect_at("preload_23_59_59", 59, 59, 23, 3, 1'b0, BL);
    step(1'b1, 1'b0, 1'b0);
    expect_at("blink_tick1", 59, 59, 23, 3, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    expect_at("blink_tick2", 59, 59, 23, 3, 1'b0, BL);
    step(1'b1, 1'b0, 1'b0);
    expect_at("blink_tick3", 59, 59, 23, 3, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    expect_at("set_hour_wrap_blink_force", 59, 59, 0, 3, 1'b0, BL);
    repeat_step(23, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    expect_at("run_blink_off", 59, 59, 23, 0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    expect_at("day_wrap_pulse", 0, 0, 0, 0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    expect_at("day_wrap_one_cycle", 0, 0, 0, 0, 1'b0, 1'b0);

    repeat_step(4, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    expect_at("mode_and_tick_in_run", 5, 0, 0, 1, 1'b0, BL);
    repeat_step(5, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    expect_at("mode_beats_inc", 10, 0, 0, 2, 1'b0, BL);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    expect_at("inc_ignored_in_run", 10, 0, 0, 0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    expect_at("tick_with_inc_in_run", 11, 0, 0, 0, 1'b0, 1'b0);

    step(1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clock_ctrl.md
Name: clock_ctrl

Overview:
- Time-keeping controller that sequences a chain of wrapping counters (seconds 0-59, minutes 0-59, hours 0-HOUR_MAX) from a single-cycle 1 Hz enable pulse.
- The pulse comes from the team's NCO divider, re-timed to a clk-domain pulse upstream.
- A 4-state mode FSM selects between free-running and manual setting of each field via two push-button pulses.
- Sits between the NCO tick source and the display/segment driver in the digital-clock top level.

Parameters:
- HOUR_MAX, 23, last hour value before wrap to 0 (11 permitted for 12-hour variants; range 1..31).
- SEC_MAX, 59, last second/minute value before wrap (shared by sec and min fields).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- tick  input  1  one-clk-wide 1 Hz enable pulse.
- btn_mode  input  1  one-clk-wide debounced mode button pulse.
- btn_inc  input  1  one-clk-wide debounced increment button pulse.
- sec  output  6  current seconds.
- min  output  6  current minutes.
- hour  output  5  current hours.
- mode  output  2  FSM state: 0 RUN, 1 SET_SEC, 2 SET_MIN, 3 SET_HOUR.
- day_wrap  output  1  one-clk pulse when time wraps HOUR_MAX:59:59 -> 00:00:00.
- blink  output  1  display blink enable for the field being set.

Behaviour:
- Reset (async assert, sync-safe release): sec=0, min=0, hour=0, mode=RUN, day_wrap=0, blink=0. Assertion mid-operation clears immediately regardless of state.
- All outputs are registered. Effects of tick/btn_mode/btn_inc sampled at edge N are visible after edge N.
- FSM: btn_mode advances RUN -> SET_SEC -> SET_MIN -> SET_HOUR -> RUN. No other transitions.
- RUN, tick=1:
  - sec increments.
  - At sec==SEC_MAX: sec->0 and min increments.
  - At min==SEC_MAX as well: min->0 and hour increments.
  - At hour==HOUR_MAX as well: hour->0 and day_wrap=1 for exactly one cycle.
- SET_x states: tick is ignored and time is frozen (no carries, day_wrap stays 0). btn_inc increments only the selected field, wrapping at its max to 0 with no carry into the next field.
- Entering SET_SEC does not clear sec. The value is kept.
- btn_mode and btn_inc in the same cycle: mode change wins, inc is discarded.
- btn_mode and tick in the same cycle while in RUN: the tick is applied (carry chain included) and mode moves to SET_SEC.
- btn_inc in RUN: ignored.
- Out-of-range values are unreachable. If HOUR_MAX is changed, comparisons use >= max, so a stray value wraps to 0 on its next increment.

Optional Feature:
- Macro CLOCK_CTRL_BLINK_EN.
- Defined:
  - blink is 0 in RUN.
  - blink is set to 1 on entry to any SET state.
  - In SET states, blink toggles on every tick.
  - blink returns to 0 on the edge entering RUN.
  - btn_inc forces blink=1 so the changed value is shown immediately.
- Undefined: blink is tied to constant 0 and no toggle flop is synthesized. All other behaviour is identical.

Decomposition:
- Shared package clock_pkg:
  - mode encoding constants MODE_RUN=2'd0, MODE_SET_SEC=2'd1, MODE_SET_MIN=2'd2, MODE_SET_HOUR=2'd3.
  - default SEC_MAX/HOUR_MAX constants.
  - field widths (6/6/5).
- Sub-module wrap_cnt:
  - parameters WIDTH and MAX.
  - inputs clk, rst, en.
  - outputs value and carry, where carry = en & (value>=MAX), combinational.
  - instantiated three times.
- clock_ctrl holds the FSM, forms each en from mode/tick/btn_inc/upstream carry, and registers day_wrap.

Test Plan:
- Reset mid-count at 00:00:37 with rst=1 for 1 cycle -> sec/min/hour=0, mode=0 on the same cycle; blink=0.
- Preload to 00:59:59 via SET states, return to RUN, 1 tick -> 01:00:00, day_wrap=0.
- Preload to 23:59:59, 1 tick -> 00:00:00 and day_wrap=1 for exactly one clk; HOUR_MAX=11 build: 11:59:59 -> 00:00:00.
- SET_MIN with min=59, btn_inc -> min=0, hour unchanged; 5 ticks in SET_MIN -> sec unchanged.
- Same-cycle btn_mode+btn_inc in SET_SEC (sec=10) -> mode=2, sec=10; same-cycle btn_mode+tick in RUN at sec=4 -> sec=5, mode=1.
- CLOCK_CTRL_BLINK_EN defined: enter SET_HOUR, 3 ticks -> blink 1,0,1,0; btn_inc -> blink=1; btn_mode -> RUN, blink=0. Undefined build: blink constant 0 throughout.
